// File: rtl/mdu_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sched_if
// Description : Bundle of the EX/ID-side signals exchanged with the
//               multiply/divide scheduler.
//               master : pipeline side (drives ops, valid, flush)
//               slave  : scheduler side (drives start, op, busy, stall,
//                        commit, sticky error)
//   id_md_op       [3:0] HI/LO-class op of the instruction in ID
//   ex_md_op       [3:0] HI/LO-class op of the instruction in EX
//   ex_valid             EX holds a real instruction
//   flush                abort request
//   mdu_start            issue pulse to the MDU
//   mdu_op         [3:0] op presented to the MDU
//   busy                 scheduler not idle
//   stall_id             hold PC/IF/ID, bubble into EX
//   hilo_commit          MDU writes HI/LO this cycle
//   err_issue_busy       sticky: mult/div reached EX while busy
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_sched_if;
    logic [3:0] id_md_op;
    logic [3:0] ex_md_op;
    logic       ex_valid;
    logic       flush;
    logic       mdu_start;
    logic [3:0] mdu_op;
    logic       busy;
    logic       stall_id;
    logic       hilo_commit;
    logic       err_issue_busy;

    modport master (
        output id_md_op, ex_md_op, ex_valid, flush,
        input  mdu_start, mdu_op, busy, stall_id, hilo_commit, err_issue_busy
    );

    modport slave (
        input  id_md_op, ex_md_op, ex_valid, flush,
        output mdu_start, mdu_op, busy, stall_id, hilo_commit, err_issue_busy
    );
endinterface
`default_nettype wire

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sched
// Description : Multi-cycle scheduler for the multiply/divide unit. Issues a
//               mult/div from EX, holds its op code for the whole run, times
//               the latency, emits a one-cycle HI/LO commit and stalls ID for
//               any HI/LO-class instruction while the unit is occupied.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-high; clears all state
//               bus   - mdu_sched_if.slave (see interface header)
// Options     : MDU_SCHED_ABORT_EN - when defined, flush aborts a running
//               op (RUN -> IDLE, no commit) and suppresses issue in IDLE.
//               When undefined, flush is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sched #(
    parameter int MULT_LAT = 5,   // issue-to-commit cycles for mult/multu
    parameter int DIV_LAT  = 10,  // issue-to-commit cycles for div/divu
    parameter int CNT_W    = 4    // holds max(MULT_LAT, DIV_LAT) - 2
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mdu_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter is loaded with LAT-2: one cycle is spent in IDLE (issue) and
    // one in DONE (commit), the rest in RUN.
    localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_LAT - 2);
    localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_LAT - 2);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_op;
    logic [3:0]       w_op_next;
    logic             r_commit;
    logic             r_err;

    logic w_ex_start;
    logic w_id_hilo;
    logic w_abort;
    logic w_issue;
    logic w_busy;

    // Ops 9..15 fall outside both ranges and therefore act as NONE.
    assign w_ex_start = bus.ex_valid && (bus.ex_md_op >= 4'd1) && (bus.ex_md_op <= 4'd4);
    assign w_id_hilo  = (bus.id_md_op >= 4'd1) && (bus.id_md_op <= 4'd8);

`ifdef MDU_SCHED_ABORT_EN
    assign w_abort = bus.flush;
`else
    logic w_unused_flush;
    assign w_unused_flush = bus.flush;
    assign w_abort        = 1'b0;
`endif

    assign w_issue = (r_state == S_IDLE) && w_ex_start && !w_abort;
    assign w_busy  = (r_state != S_IDLE);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_op_next  = r_op;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_op_next  = bus.ex_md_op;
                    w_cnt_next = (bus.ex_md_op <= 4'd2) ? c_mult_cnt : c_div_cnt;
                    w_next     = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_next     = S_IDLE;
                    w_op_next  = 4'd0;
                    w_cnt_next = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_next = S_DONE;
                end
            end
            // Flush is deliberately not looked at here: the commit completes.
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= 4'd0;
            r_commit <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_op     <= w_op_next;
            // Commit flag is registered alongside the DONE state it marks.
            r_commit <= (w_next == S_DONE);
            // A start op while occupied is dropped; remember that it happened.
            if (w_busy && w_ex_start) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.mdu_start      = w_issue;
    assign bus.mdu_op         = w_busy ? r_op : (bus.ex_valid ? bus.ex_md_op : 4'd0);
    assign bus.busy           = w_busy;
    assign bus.stall_id       = w_id_hilo && (w_busy || w_issue);
    assign bus.hilo_commit    = r_commit;
    assign bus.err_issue_busy = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_sched
// Description : Self-checking bench for mdu_sched. A reference model tracks
//               the number of cycles remaining until the unit is free again;
//               every cycle all outputs are compared against it, with extra
//               directed checks at the documented timing points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
`ifdef MDU_SCHED_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mdu_sched_if bus ();

    mdu_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: cycles left until the unit is free (commit at 1).
    int         m_rem = 0;
    logic [3:0] m_op = 4'd0;
    logic       m_err = 1'b0;
    logic       e_issue;
    logic [3:0] cur_ex;
    logic       cur_ev;
    logic       cur_fl;

    function automatic bit is_start(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic bit is_hilo(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        return (op <= 4'd2) ? MULT_LAT : DIV_LAT;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] id_op, input logic [3:0] ex_op,
                         input logic ev, input logic fl);
        @(negedge clk);
        bus.id_md_op = id_op;
        bus.ex_md_op = ex_op;
        bus.ex_valid = ev;
        bus.flush    = fl;
        cur_ex = ex_op;
        cur_ev = ev;
        cur_fl = fl;
        #1;
    endtask

    task automatic check_model();
        logic       e_busy;
        logic [3:0] e_op;
        e_busy  = (m_rem > 0);
        e_issue = (m_rem == 0) && cur_ev && is_start(cur_ex) && !(ABORT && cur_fl);
        e_op    = (m_rem == 0) ? (cur_ev ? cur_ex : 4'd0) : m_op;
        chk("busy",        32'(bus.busy),           32'(e_busy));
        chk("mdu_start",   32'(bus.mdu_start),      32'(e_issue));
        chk("mdu_op",      32'(bus.mdu_op),         32'(e_op));
        chk("hilo_commit", 32'(bus.hilo_commit),    32'(m_rem == 1));
        chk("stall_id",    32'(bus.stall_id),       32'(is_hilo(bus.id_md_op) && (e_busy || e_issue)));
        chk("err",         32'(bus.err_issue_busy), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_rem > 0 && cur_ev && is_start(cur_ex)) m_err = 1'b1;
        if (e_issue) begin
            m_rem = lat_of(cur_ex);
            m_op  = cur_ex;
        end else if (m_rem > 1 && ABORT && cur_fl) begin
            m_rem = 0;
            m_op  = 4'd0;
        end else if (m_rem > 0) begin
            m_rem--;
        end
    endtask

    task automatic cyc(input logic [3:0] id_op, input logic [3:0] ex_op,
                       input logic ev, input logic fl);
        drive(id_op, ex_op, ev, fl);
        check_model();
        tick();
    endtask

    task automatic model_reset();
        m_rem = 0;
        m_op  = 4'd0;
        m_err = 1'b0;
    endtask

    initial begin
        bus.id_md_op = 4'd0;
        bus.ex_md_op = 4'd0;
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b0;
        cur_ex = 4'd0; cur_ev = 1'b0; cur_fl = 1'b0;

        // Reset values
        #3;
        chk("rst_busy",   32'(bus.busy),           32'd0);
        chk("rst_start",  32'(bus.mdu_start),      32'd0);
        chk("rst_commit", 32'(bus.hilo_commit),    32'd0);
        chk("rst_stall",  32'(bus.stall_id),       32'd0);
        chk("rst_err",    32'(bus.err_issue_busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // MULT issue: start at T, busy T+1..T+5, commit only at T+5
        drive(4'd0, 4'd1, 1'b1, 1'b0);
        check_model();
        chk("mult_start", 32'(bus.mdu_start), 32'd1);
        tick();
        for (int k = 1; k <= MULT_LAT; k++) begin
            drive(4'd0, 4'd0, 1'b0, 1'b0);
            check_model();
            chk("mult_busy",   32'(bus.busy),        32'd1);
            chk("mult_commit", 32'(bus.hilo_commit), 32'(k == MULT_LAT));
            tick();
        end
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        check_model();
        chk("mult_idle", 32'(bus.busy), 32'd0);
        tick();

        // DIV with MFLO waiting in ID
        drive(4'd6, 4'd3, 1'b1, 1'b0);
        check_model();
        chk("div_stall_T", 32'(bus.stall_id), 32'd1);
        tick();
        for (int k = 1; k <= DIV_LAT; k++) begin
            drive(4'd6, 4'd0, 1'b0, 1'b0);
            check_model();
            chk("div_stall",  32'(bus.stall_id),    32'd1);
            chk("div_commit", 32'(bus.hilo_commit), 32'(k == DIV_LAT));
            tick();
        end
        drive(4'd0, 4'd6, 1'b1, 1'b0);
        check_model();
        chk("mflo_stall", 32'(bus.stall_id), 32'd0);
        chk("mflo_op",    32'(bus.mdu_op),   32'd6);
        tick();

        // MTHI in EX while idle; then a mult with a non-HI/LO op in ID
        drive(4'd0, 4'd7, 1'b1, 1'b0);
        check_model();
        chk("mthi_op",    32'(bus.mdu_op),    32'd7);
        chk("mthi_start", 32'(bus.mdu_start), 32'd0);
        tick();
        drive(4'd0, 4'd2, 1'b1, 1'b0);
        check_model();
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        tick();
        for (int k = 1; k <= MULT_LAT; k++) begin
            drive(4'd0, 4'd0, 1'b1, 1'b0);
            check_model();
            chk("add_nostall", 32'(bus.stall_id), 32'd0);
            tick();
        end

        // MULTU forced into EX at T+2 of a DIV
        cyc(4'd0, 4'd3, 1'b1, 1'b0);
        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        drive(4'd0, 4'd2, 1'b1, 1'b0);
        check_model();
        chk("reissue_start", 32'(bus.mdu_start), 32'd0);
        chk("reissue_op",    32'(bus.mdu_op),    32'd3);
        tick();
        for (int k = 3; k <= DIV_LAT; k++) begin
            drive(4'd0, 4'd0, 1'b0, 1'b0);
            check_model();
            chk("reissue_err",    32'(bus.err_issue_busy), 32'd1);
            chk("reissue_commit", 32'(bus.hilo_commit),    32'(k == DIV_LAT));
            tick();
        end
        cyc(4'd0, 4'd0, 1'b0, 1'b0);

        // Flush at T+3 of a MULT
        cyc(4'd0, 4'd1, 1'b1, 1'b0);
        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        cyc(4'd0, 4'd0, 1'b0, 1'b0);
        cyc(4'd0, 4'd0, 1'b0, 1'b1);
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        check_model();
        chk("flush_busy", 32'(bus.busy), ABORT ? 32'd0 : 32'd1);
        tick();
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        check_model();
        chk("flush_commit", 32'(bus.hilo_commit), ABORT ? 32'd0 : 32'd1);
        tick();
        cyc(4'd0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset at T+4 of a DIV
        cyc(4'd5, 4'd4, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) cyc(4'd5, 4'd0, 1'b0, 1'b0);
        drive(4'd5, 4'd0, 1'b0, 1'b0);
        check_model();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy",   32'(bus.busy),           32'd0);
        chk("arst_commit", 32'(bus.hilo_commit),    32'd0);
        chk("arst_stall",  32'(bus.stall_id),       32'd0);
        chk("arst_err",    32'(bus.err_issue_busy), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) cyc(4'd0, 4'd0, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
